// File: rtl/servo_pkg.sv
// Shared servo timing defaults, FSM state encoding and the command clamp helper.
package servo_pkg;

  localparam int unsigned PERIOD_DEFAULT = 32'd1000000;
  localparam int unsigned MIN_DEFAULT    = 32'd50000;
  localparam int unsigned MAX_DEFAULT    = 32'd100000;
  localparam int unsigned CENTER_DEFAULT = 32'd75000;
  localparam int unsigned SLEW_DEFAULT   = 32'd500;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } servo_state_e;

  function automatic logic [31:0] clamp_width(input logic [31:0] w,
                                               input logic [31:0] lo,
                                               input logic [31:0] hi);
    if (w < lo) begin
      return lo;
    end else if (w > hi) begin
      return hi;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/servo_pwm_driver_if.sv
// Command and status bundle between a servo controller and servo_pwm_driver.
interface servo_pwm_driver_if;
  logic        enable;
  logic [31:0] cmd_width;
  logic        cmd_valid;
  logic        pwm_out;
  logic [31:0] cur_width;
  logic        frame_start;
  logic        at_target;

  modport master (
    output enable, cmd_width, cmd_valid,
    input  pwm_out, cur_width, frame_start, at_target
  );

  modport slave (
    input  enable, cmd_width, cmd_valid,
    output pwm_out, cur_width, frame_start, at_target
  );
endinterface

// File: rtl/servo_width_slew.sv
// Next applied width: move toward target by at most SLEW_STEP (0 jumps straight there).
module servo_width_slew
  import servo_pkg::*;
#(
  parameter int unsigned SLEW_STEP = SLEW_DEFAULT
) (
  input  logic [31:0] i_cur_width,
  input  logic [31:0] i_target,
  output logic [31:0] o_next_width
);

  localparam logic [31:0] LP_STEP = 32'(SLEW_STEP);

  logic signed [32:0] w_diff;
  logic signed [32:0] w_mag;

  always_comb begin
    w_diff = $signed({1'b0, i_target}) - $signed({1'b0, i_cur_width});
    w_mag  = w_diff[32] ? -w_diff : w_diff;
    if ((LP_STEP == 32'd0) || (w_mag <= $signed({1'b0, LP_STEP}))) begin
      o_next_width = i_target;
    end else if (w_diff[32]) begin
      o_next_width = i_cur_width - LP_STEP;
    end else begin
      o_next_width = i_cur_width + LP_STEP;
    end
  end

endmodule

// File: rtl/servo_pwm_driver.sv
// Servo PWM frame generator: clamped target, slewed width, updates only at frame boundaries.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = PERIOD_DEFAULT,
  parameter int unsigned MIN_WIDTH     = MIN_DEFAULT,
  parameter int unsigned MAX_WIDTH     = MAX_DEFAULT,
  parameter int unsigned CENTER_WIDTH  = CENTER_DEFAULT,
  parameter int unsigned SLEW_STEP     = SLEW_DEFAULT
) (
  input logic              clock_clk,
  input logic              reset_low,
  servo_pwm_driver_if.slave bus
);

  if (!((MIN_WIDTH > 0) && (MIN_WIDTH <= CENTER_WIDTH) &&
        (CENTER_WIDTH <= MAX_WIDTH) && (MAX_WIDTH < PERIOD_CYCLES))) begin : g_param_check
    $error("servo_pwm_driver: width parameters out of order");
  end

  localparam logic [31:0] LP_LAST   = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] LP_MIN    = 32'(MIN_WIDTH);
  localparam logic [31:0] LP_MAX    = 32'(MAX_WIDTH);
  localparam logic [31:0] LP_CENTER = 32'(CENTER_WIDTH);

  servo_state_e r_state;
  logic [31:0]  r_cnt;
  logic [31:0]  r_target;
  logic [31:0]  r_cur;
  logic         r_pwm;
  logic         r_fs;

  servo_state_e w_state_nxt;
  logic [31:0]  w_cnt_nxt;
  logic [31:0]  w_slew_width;
  logic [31:0]  w_width_eff;
  logic         w_new_frame;
  logic         w_pwm_nxt;

  servo_width_slew #(.SLEW_STEP(SLEW_STEP)) u_slew (
    .i_cur_width (r_cur),
    .i_target    (r_target),
    .o_next_width(w_slew_width)
  );

  // A frame may only end on its last cycle, so disabling mid-frame just drains it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = 32'd0;
    w_new_frame = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.enable) begin
          w_state_nxt = ST_RUN;
          w_new_frame = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (r_cnt == LP_LAST) begin
          if (bus.enable) begin
            w_state_nxt = ST_RUN;
            w_new_frame = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt   = r_cnt + 32'd1;
          w_state_nxt = bus.enable ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_width_eff = w_new_frame ? w_slew_width : r_cur;
    w_pwm_nxt   = (w_state_nxt != ST_IDLE) && (w_cnt_nxt < w_width_eff);
  end

  // Frame state, counter, applied width and the registered pin outputs.
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      r_state <= ST_IDLE;
      r_cnt   <= 32'd0;
      r_cur   <= LP_CENTER;
      r_pwm   <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cur   <= w_width_eff;
      r_pwm   <= w_pwm_nxt;
      r_fs    <= w_new_frame;
    end
  end

  // Target latch; a strobe on a boundary edge is seen by the following boundary.
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      r_target <= LP_CENTER;
    end else if (bus.cmd_valid) begin
      r_target <= clamp_width(bus.cmd_width, LP_MIN, LP_MAX);
    end else begin
      r_target <= r_target;
    end
  end

  assign bus.pwm_out     = r_pwm;
  assign bus.frame_start = r_fs;
  assign bus.cur_width   = r_cur;
  assign bus.at_target   = (r_cur == r_target);

endmodule

// File: doc/servo_pwm_driver.md
Name: servo_pwm_driver

Overview:
Generates the PWM command pulse train that drives the forklift steering/lift servo. Its output pulse width is then measured back by servo_feedback.
- Accepts a target pulse width in clock cycles and clamps it to a safe range.
- Slews the applied width toward the target by a bounded step per frame.
- Changes the applied width only at frame boundaries, so no pulse is ever truncated or glitched.

Parameters:
PERIOD_CYCLES, 1000000, frame length in clocks (20 ms at 50 MHz)
MIN_WIDTH, 50000, minimum legal high time in clocks (1 ms)
MAX_WIDTH, 100000, maximum legal high time in clocks (2 ms)
CENTER_WIDTH, 75000, width applied after reset (1.5 ms, neutral)
SLEW_STEP, 500, maximum change of applied width per frame; 0 = unlimited (jump directly to target)
Constraint: 0 < MIN_WIDTH <= CENTER_WIDTH <= MAX_WIDTH < PERIOD_CYCLES. Violation is an elaboration error.

Ports:
clock_clk  input  1  system clock
reset_low  input  1  asynchronous, active-low reset
enable  input  1  level; 1 = generate frames
cmd_width  input  32  requested high time in clocks
cmd_valid  input  1  one-cycle strobe; latches cmd_width as the new target
pwm_out  output  1  servo PWM signal
cur_width  output  32  width applied in the current frame
frame_start  output  1  one-cycle pulse on the first cycle of each frame
at_target  output  1  1 when cur_width == target

Behaviour:
- Reset state (async assert, all registers):
  - pwm_out=0, frame_start=0
  - frame counter=0
  - target=CENTER_WIDTH, cur_width=CENTER_WIDTH, at_target=1
  - FSM=IDLE
- Target latch:
  - On a cycle with cmd_valid=1, target <= clamp(cmd_width, MIN_WIDTH, MAX_WIDTH) using unsigned compare.
  - Accepted in any state. The last strobe wins.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: pwm_out=0, counter held at 0. On enable=1 -> RUN. The cycle after enable is first sampled high is frame cycle 0.
  - RUN: counter counts 0..PERIOD_CYCLES-1 and wraps. If enable=0 is sampled -> DRAIN; the current frame continues unchanged.
  - DRAIN: frame runs to completion.
    - Reaching cycle PERIOD_CYCLES-1 with enable=0 -> IDLE; pwm_out low, counter 0.
    - If enable=1 is seen before the last cycle -> RUN, with no frame restart.
- Frame timing:
  - frame_start=1 exactly on frame cycle 0.
  - pwm_out=1 on frame cycles 0..cur_width-1 and 0 on cycles cur_width..PERIOD_CYCLES-1.
  - pwm_out and frame_start are registered outputs, aligned to the same cycle.
- Width update:
  - Occurs only on the transition into frame cycle 0 of a new frame, including the first frame after IDLE.
  - Rule, with d = target - cur_width:
    - |d| <= SLEW_STEP or SLEW_STEP=0: cur_width <= target
    - otherwise: cur_width <= cur_width ± SLEW_STEP
  - The new width applies to that frame.
  - Use signed 33-bit difference arithmetic; no wrap is possible because both operands lie in [MIN,MAX].
- Simultaneous events:
  - cmd_valid on the same cycle as the frame-boundary update: the update uses the old target; the new target is used at the next boundary.
  - In IDLE, cur_width still updates at the first frame start only, not continuously.
- at_target: combinational compare of the cur_width and target registers.
- Reset mid-frame: pwm_out drops low asynchronously. After release the block starts from IDLE at CENTER_WIDTH.

Decomposition:
- Package servo_pkg holds:
  - default timing constants (PERIOD, MIN, MAX, CENTER), shared with servo_feedback bench checks
  - FSM state enum {IDLE, RUN, DRAIN}
- One sub-module, servo_width_slew: purely combinational.
  - Inputs: cur_width, target, SLEW_STEP.
  - Output: next width.
  - Unit-testable in isolation.

Test Plan:
Bench parameters: PERIOD=100, MIN=10, MAX=20, CENTER=15, SLEW=2.
1. Reset then enable=1, no command -> frame_start every 100 cycles; pwm_out high 15 cycles/frame; at_target=1.
2. cmd_width=20 during frame 0 -> cur_width 17, 19, 20 on the next three frames; at_target rises with the frame of width 20; every pulse has exactly that width.
3. cmd_width=3, then cmd_width=500 -> targets clamp to 10 and 20; cur_width never leaves [10,20].
4. cmd_valid (value 10) on frame cycle 0 with cur_width=15 and target=15 -> no change in that frame; next frame 13.
5. enable=0 at frame cycle 40 -> frame completes (15 high, 85 low), then IDLE with pwm_out=0 and frame_start silent. Second run: enable toggled 0 then 1 within a frame -> no truncation; next frame_start exactly 100 cycles after the previous one.
6. reset_low asserted at frame cycle 5 while pwm_out=1 -> pwm_out=0 immediately. After release, enable gives a first pulse of 15 cycles.
